uart_str_tx: RTL

Parametrised UART message transmitter: a writable message buffer of up to MSG_LEN characters, a sequencer, and a frame serializer with selectable baud, parity and stop bits. One start pulse sends the first len characters back-to-back on tx, either once or continuously. It replaces the fixed-string, fixed-8N1 key-triggered sender and sits behind key_filter, with key_flag & !key_state driving start.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frame_tx.sv | 72 +++++++
 rtl/uart_str_tx.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared baud, parity and state definitions for the UART message transmitter
package uart_pkg;
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [1:0] {M_IDLE, M_FETCH, M_SEND} msg_state_t;
  typedef enum logic [2:0] {F_IDLE, F_START, F_DATA, F_PARITY, F_STOP} frm_state_t;
  // Cycles per bit rounded to nearest; unknown selects fall back to 9600
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    int unsigned rate;
    rate = sel == BAUD_19200 ? 19200 : sel == BAUD_38400 ? 38400 :
           sel == BAUD_57600 ? 57600 : sel == BAUD_115200 ? 115200 : 9600;
    return (clk_freq + rate / 2) / rate;
  endfunction
endpackage

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serializes one character as start, LSB-first data, optional parity and stop bits
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DW        = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        i_div,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_frame_done
);
  frm_state_t r_state;
  logic [DW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [DATA_BITS-1:0] r_sh;
  logic r_par;
  logic r_tx;
  logic w_last;
  assign w_last = r_cnt == i_div - 1'b1;
  assign o_tx = r_tx;
  assign o_frame_done = r_state == F_STOP && r_bit == 3'(STOP_BITS - 1) && w_last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= F_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_tx <= 1'b1;
    end else if (r_state == F_IDLE) begin
      if (i_load) begin
        r_state <= F_START;
        r_cnt <= '0;
        r_sh <= i_data;
        r_par <= ^i_data ^ (PARITY == PAR_ODD);
        r_tx <= 1'b0;
      end
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last)
        case (r_state)
          F_START: begin
            r_state <= F_DATA;
            r_bit <= '0;
            r_tx <= r_sh[0];
            r_sh <= r_sh >> 1;
          end
          F_DATA:
            if (r_bit == 3'(DATA_BITS - 1)) begin
              r_state <= PARITY != PAR_NONE ? F_PARITY : F_STOP;
              r_bit <= '0;
              r_tx <= PARITY != PAR_NONE ? r_par : 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx <= r_sh[0];
              r_sh <= r_sh >> 1;
            end
          F_PARITY: begin
            r_state <= F_STOP;
            r_tx <= 1'b1;
          end
          default:
            if (r_bit == 3'(STOP_BITS - 1)) r_state <= F_IDLE;
            else r_bit <= r_bit + 1'b1;
        endcase
    end
  end
endmodule

// File: rtl/uart_str_tx.sv
// uart_str_tx: sends the first len characters of a writable buffer as UART frames, once or repeatedly
module uart_str_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int MSG_LEN   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int AW        = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1,
  parameter int LW        = $clog2(MSG_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           baud_set,
  input  logic                 start,
  input  logic                 repeat_en,
  input  logic [LW-1:0]        len,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done,
  output logic                 msg_done
);
  localparam int unsigned D0 = baud_div(CLK_FREQ, BAUD_9600);
  localparam int unsigned D1 = baud_div(CLK_FREQ, BAUD_19200);
  localparam int unsigned D2 = baud_div(CLK_FREQ, BAUD_38400);
  localparam int unsigned D3 = baud_div(CLK_FREQ, BAUD_57600);
  localparam int unsigned D4 = baud_div(CLK_FREQ, BAUD_115200);
  localparam int DW = $clog2(D0 + 1);
  msg_state_t r_state;
  logic [DATA_BITS-1:0] r_buf [MSG_LEN];
  logic [AW-1:0] r_idx;
  logic [LW-1:0] r_len;
  logic [DW-1:0] r_div;
  logic r_busy;
  logic [DW-1:0] w_div;
  logic [LW-1:0] w_len;
  logic w_frame_done;
  logic w_last_chr;
  // Divider is chosen from constants so no runtime divide is built
  assign w_div = baud_set == BAUD_19200 ? DW'(D1) : baud_set == BAUD_38400 ? DW'(D2) :
                 baud_set == BAUD_57600 ? DW'(D3) : baud_set == BAUD_115200 ? DW'(D4) : DW'(D0);
  assign w_len = len > LW'(MSG_LEN) ? LW'(MSG_LEN) : len;
  assign w_last_chr = LW'(r_idx) == r_len - 1'b1;
  assign busy = r_busy;
  assign byte_done = w_frame_done;
  assign msg_done = w_frame_done && w_last_chr;
  always_ff @(posedge clk) begin
    if (wr_en) r_buf[wr_addr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= M_IDLE;
      r_busy <= 1'b0;
      r_idx <= '0;
      r_len <= '0;
      r_div <= DW'(D0);
    end else
      case (r_state)
        M_IDLE:
          if (start && w_len != '0) begin
            r_state <= M_FETCH;
            r_busy <= 1'b1;
            r_idx <= '0;
            r_len <= w_len;
            r_div <= w_div;
          end
        M_FETCH: r_state <= M_SEND;
        M_SEND:
          if (w_frame_done) begin
            r_idx <= w_last_chr ? '0 : r_idx + 1'b1;
            r_state <= !w_last_chr || repeat_en ? M_FETCH : M_IDLE;
            r_busy <= !w_last_chr || repeat_en;
          end
        default: r_state <= M_IDLE;
      endcase
  end
  uart_frame_tx #(
    .DATA_BITS(DATA_BITS),
    .PARITY(PARITY),
    .STOP_BITS(STOP_BITS),
    .DW(DW)
  ) u_frame (
    .clk(clk),
    .rst_n(rst_n),
    .i_div(r_div),
    .i_load(r_state == M_FETCH),
    .i_data(r_buf[r_idx]),
    .o_tx(tx),
    .o_frame_done(w_frame_done)
  );
endmodule
